// File: rtl/mm_skew_sequencer_pkg.sv
// mm_pkg: shared defaults, sequencer state encoding and lane slicing for
// the systolic matrix-multiply operand sequencer.
//   MM_N / MM_DW : default array dimension and element width
//   state_e      : IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE
//   lane_lsb()   : LSB of lane `lane` on an N*DW bus (lane 0 at the MSBs)
package mm_pkg;

    localparam int unsigned MM_N  = 9;
    localparam int unsigned MM_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Lane i occupies [dw*(n-i)-1 : dw*(n-i-1)].
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned n,
                                             input int unsigned dw);
        return dw * (n - lane - 1);
    endfunction

endpackage

// File: rtl/mm_operand_buf.sv
// mm_operand_buf: N x N x DW operand register file with one write port and a
// skewed read port producing a full wavefront for step t.
//   clk, rst_n       : clock, async active-low reset (clears all entries)
//   wr_en_i          : write strobe (caller qualifies with FSM state)
//   wr_row_i/wr_col_i: element indices; out-of-range writes are dropped
//   wr_data_i        : element value
//   rd_step_i        : wavefront step t
//   rd_lanes_o       : N*DW lanes; COL_ORIENT=0 -> lane i = M[i][t-i],
//                      COL_ORIENT=1 -> lane j = M[t-j][j]; zero outside range
module mm_operand_buf
    import mm_pkg::*;
#(
    parameter int unsigned N          = MM_N,
    parameter int unsigned DW         = MM_DW,
    parameter int unsigned STEP_W     = 5,
    parameter bit          COL_ORIENT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [3:0]          wr_row_i,
    input  logic [3:0]          wr_col_i,
    input  logic [DW-1:0]       wr_data_i,
    input  logic [STEP_W-1:0]   rd_step_i,
    output logic [N*DW-1:0]     rd_lanes_o
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] mem_q [N][N];

    // Element storage; indices outside the N x N grid never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (wr_en_i && (32'(wr_row_i) < N) && (32'(wr_col_i) < N)) begin
            mem_q[IDX_W'(wr_row_i)][IDX_W'(wr_col_i)] <= wr_data_i;
        end
    end

    // Skewed read: lane l sees element index k = t - l along its orientation.
    always_comb begin
        int k;
        k          = 0;
        rd_lanes_o = '0;
        for (int l = 0; l < int'(N); l++) begin
            k = int'(rd_step_i) - l;
            if (k >= 0 && k < int'(N)) begin
                if (COL_ORIENT) begin
                    rd_lanes_o[lane_lsb(l, N, DW) +: DW] = mem_q[IDX_W'(k)][IDX_W'(l)];
                end else begin
                    rd_lanes_o[lane_lsb(l, N, DW) +: DW] = mem_q[IDX_W'(l)][IDX_W'(k)];
                end
            end
        end
    end

endmodule

// File: rtl/mm_skew_sequencer.sv
// mm_skew_sequencer: owns the A/W operand buffers of the N x N systolic
// multiply array and, per start, clears the accumulators, streams 2N-1
// skewed wavefronts, zero-fills DRAIN_CYC cycles and pulses done.
//   clk, reset        : clock, async active-low reset
//   wr_en/wr_sel      : element write (0 = A data, 1 = W weight), IDLE only
//   wr_row/wr_col     : element indices (>= N dropped)
//   wr_data           : element value
//   start             : begin a run (sampled only in IDLE)
//   busy/done         : run in progress / one-cycle completion pulse
//   arr_clear         : one-cycle accumulator clear
//   data_arr/wt_arr   : skewed A / W lanes, lane 0 at the MSBs
// Optional MM_SEQ_RUNCNT_EN adds run_cnt[15:0], counting completed runs.
module mm_skew_sequencer
    import mm_pkg::*;
#(
    parameter int unsigned N         = MM_N,
    parameter int unsigned DW        = MM_DW,
    parameter int unsigned DRAIN_CYC = 18
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [3:0]      wr_row,
    input  logic [3:0]      wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            arr_clear,
    output logic [N*DW-1:0] data_arr,
    output logic [N*DW-1:0] wt_arr
`ifdef MM_SEQ_RUNCNT_EN
    ,
    output logic [15:0]     run_cnt
`endif
);

    localparam int unsigned STEP_W   = $clog2(2 * N);
    localparam int unsigned STEP_END = 2 * N - 1;
    localparam int unsigned DRN_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int unsigned DRN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    state_e              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [DRN_W-1:0]    drain_q;
    logic                busy_q;
    logic                done_q;
    logic                clear_q;
    logic [N*DW-1:0]     data_q;
    logic [N*DW-1:0]     wt_q;
    logic [N*DW-1:0]     a_lanes_c;
    logic [N*DW-1:0]     w_lanes_c;
    logic                wr_ok_c;

    // Host writes only land while idle, including the start cycle itself.
    assign wr_ok_c = wr_en && (state_q == ST_IDLE);

    mm_operand_buf #(
        .N          (N),
        .DW         (DW),
        .STEP_W     (STEP_W),
        .COL_ORIENT (1'b0)
    ) u_a_buf (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (wr_ok_c && !wr_sel),
        .wr_row_i   (wr_row),
        .wr_col_i   (wr_col),
        .wr_data_i  (wr_data),
        .rd_step_i  (step_q),
        .rd_lanes_o (a_lanes_c)
    );

    mm_operand_buf #(
        .N          (N),
        .DW         (DW),
        .STEP_W     (STEP_W),
        .COL_ORIENT (1'b1)
    ) u_w_buf (
        .clk        (clk),
        .rst_n      (reset),
        .wr_en_i    (wr_ok_c && wr_sel),
        .wr_row_i   (wr_row),
        .wr_col_i   (wr_col),
        .wr_data_i  (wr_data),
        .rd_step_i  (step_q),
        .rd_lanes_o (w_lanes_c)
    );

    // Sequencer FSM with registered outputs. step_q names the wavefront the
    // next edge loads, so CLEAR already presents step 0 to the buffers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            data_q  <= '0;
            wt_q    <= '0;
        end else begin
            clear_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            wt_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    step_q <= '0;
                    if (start) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        clear_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_FEED;
                    data_q  <= a_lanes_c;
                    wt_q    <= w_lanes_c;
                    step_q  <= STEP_W'(1);
                end
                ST_FEED: begin
                    if (step_q == STEP_W'(STEP_END)) begin
                        step_q  <= '0;
                        drain_q <= '0;
                        if (DRAIN_CYC == 0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        data_q <= a_lanes_c;
                        wt_q   <= w_lanes_c;
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRN_W'(DRN_LAST)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        drain_q <= '0;
                    end else begin
                        drain_q <= drain_q + DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign arr_clear = clear_q;
    assign data_arr  = data_q;
    assign wt_arr    = wt_q;

`ifdef MM_SEQ_RUNCNT_EN
    logic [15:0] run_cnt_q;

    // Completed-run counter; wraps naturally and is untouched by start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_q <= '0;
        end else if (state_q == ST_DONE) begin
            run_cnt_q <= run_cnt_q + 16'd1;
        end
    end

    assign run_cnt = run_cnt_q;
`endif

endmodule

// File: tb/tb_mm_skew_sequencer.sv
// Directed bench for mm_skew_sequencer (N=9, DW=32, DRAIN_CYC=18).
module tb_mm_skew_sequencer;

    localparam int unsigned N         = 9;
    localparam int unsigned DW        = 32;
    localparam int unsigned DRAIN_CYC = 18;
    localparam int unsigned BW        = N * DW;
    localparam int unsigned RUN_LEN   = 2 * N + DRAIN_CYC + 2;   // samples k = 0..37
    localparam logic [DW-1:0] ONE     = 32'h3F80_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic            wr_sel;
    logic [3:0]      wr_row;
    logic [3:0]      wr_col;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            arr_clear;
    logic [BW-1:0]   data_arr;
    logic [BW-1:0]   wt_arr;
`ifdef MM_SEQ_RUNCNT_EN
    logic [15:0]     run_cnt;
`endif

    logic [DW-1:0]   a_mdl [N][N];
    logic [DW-1:0]   w_mdl [N][N];
    logic [BW-1:0]   d_cap [RUN_LEN];
    logic [BW-1:0]   w_cap [RUN_LEN];
    int              checks = 0;
    int              errors = 0;
    int              runs_mdl = 0;

    always #5 clk = ~clk;

    mm_skew_sequencer #(
        .N         (N),
        .DW        (DW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .arr_clear (arr_clear),
        .data_arr  (data_arr),
        .wt_arr    (wt_arr)
`ifdef MM_SEQ_RUNCNT_EN
        ,
        .run_cnt   (run_cnt)
`endif
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] exp_lanes(input int t, input bit wt);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (t - i >= 0 && t - i < int'(N)) begin
                v[DW*(N-i)-1 -: DW] = wt ? w_mdl[t-i][i] : a_mdl[i][t-i];
            end
        end
        return v;
    endfunction

    task automatic clear_models();
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                a_mdl[r][c] = '0;
                w_mdl[r][c] = '0;
            end
    endtask

    task automatic write_elem(input bit sel, input int row, input int col, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 4'(row);
        wr_col  = 4'(col);
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Raise start for one sampling edge; returns just after E0.
    task automatic do_start(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        if (!hold) #1 start = 1'b0;
    endtask

    // Called just after E0; sample k is the cycle after edge Ek.
    task automatic run_and_check(input string name, input bit busy_wr);
        for (int k = 0; k < int'(RUN_LEN); k++) begin
            logic [2:0]    fexp;
            logic [BW-1:0] dexp;
            logic [BW-1:0] wexp;
            @(negedge clk);
            dexp = '0;
            wexp = '0;
            if (k == 0)                              fexp = 3'b101;
            else if (k == int'(2*N + DRAIN_CYC))     fexp = 3'b110;
            else if (k == int'(RUN_LEN) - 1)         fexp = 3'b000;
            else                                     fexp = 3'b100;
            if (k >= 1 && k <= int'(2*N - 1)) begin
                dexp = exp_lanes(k - 1, 1'b0);
                wexp = exp_lanes(k - 1, 1'b1);
            end
            d_cap[k] = data_arr;
            w_cap[k] = wt_arr;
            check($sformatf("%s k%0d busy/done/clr", name, k), BW'({busy, done, arr_clear}), BW'(fexp));
            check($sformatf("%s k%0d data", name, k), data_arr, dexp);
            check($sformatf("%s k%0d wt", name, k), wt_arr, wexp);
            if (busy_wr) begin
                if (k >= 2 && k < 22) begin
                    wr_en   = 1'b1;
                    wr_sel  = bit'(k % 2);
                    wr_row  = 4'(k % 9);
                    wr_col  = 4'((k + 3) % 9);
                    wr_data = 32'hDEAD_0000 | DW'(k);
                end else begin
                    wr_en = 1'b0;
                end
            end
            if (k < int'(RUN_LEN) - 1) @(posedge clk);
        end
        runs_mdl++;
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        start   = 1'b0;
        clear_models();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset flags", BW'({busy, done, arr_clear}), '0);
        check("reset data", data_arr, '0);
        check("reset wt", wt_arr, '0);
        reset = 1'b1;

        // Identity x all-ones
        for (int i = 0; i < int'(N); i++) begin
            write_elem(1'b0, i, i, ONE);
            a_mdl[i][i] = ONE;
            for (int j = 0; j < int'(N); j++) begin
                write_elem(1'b1, i, j, ONE);
                w_mdl[i][j] = ONE;
            end
        end
        do_start(1'b0);
        run_and_check("ident", 1'b0);
        check("ident step0 data", d_cap[1], {ONE, 256'h0});
        check("ident step0 wt",   w_cap[1], {ONE, 256'h0});
        check("ident step8 data", d_cap[9], {128'h0, ONE, 128'h0});
        check("ident step8 wt",   w_cap[9], {9{ONE}});
        check("ident step16 data", d_cap[17], {256'h0, ONE});
        check("ident step16 wt",   w_cap[17], {256'h0, ONE});

        // Skew ordering with index-encoded elements
        for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
                write_elem(1'b0, r, c, DW'(r * 16 + c));
                write_elem(1'b1, r, c, DW'(r * 16 + c));
                a_mdl[r][c] = DW'(r * 16 + c);
                w_mdl[r][c] = DW'(r * 16 + c);
            end
        do_start(1'b0);
        run_and_check("skew", 1'b0);
        check("skew step4 data", d_cap[5], {32'h04, 32'h13, 32'h22, 32'h31, 32'h40, 128'h0});
        check("skew step4 wt",   w_cap[5], {32'h40, 32'h31, 32'h22, 32'h13, 32'h04, 128'h0});

        // Out-of-range writes dropped; writes while busy dropped
        write_elem(1'b0, 9, 0, 32'hFFFF_FFFF);
        write_elem(1'b1, 0, 9, 32'hFFFF_FFFF);
        write_elem(1'b0, 15, 15, 32'hFFFF_FFFF);
        do_start(1'b0);
        run_and_check("busywr", 1'b1);
        do_start(1'b0);
        run_and_check("rerun", 1'b0);

        // Same-cycle write and start
        @(negedge clk);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = 4'd0;
        wr_col  = 4'd0;
        wr_data = 32'h4040_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        a_mdl[0][0] = 32'h4040_0000;
        run_and_check("wrstart", 1'b0);
        check("wrstart lane0", BW'(d_cap[1][BW-1 -: DW]), BW'(32'h4040_0000));

        // start held high: one run per IDLE visit, one idle cycle between
        do_start(1'b1);
        run_and_check("hold1", 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        run_and_check("hold2", 1'b0);

        // Reset during FEED step 5
        do_start(1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("prereset data", data_arr, exp_lanes(5, 1'b0));
        reset = 1'b0;
        #1;
        check("midreset flags", BW'({busy, done, arr_clear}), '0);
        check("midreset data", data_arr, '0);
        check("midreset wt", wt_arr, '0);
        @(negedge clk);
        reset = 1'b1;
        clear_models();
        runs_mdl = 0;
        do_start(1'b0);
        run_and_check("postreset", 1'b0);
        do_start(1'b0);
        run_and_check("postreset2", 1'b0);
        do_start(1'b0);
        run_and_check("postreset3", 1'b0);
`ifdef MM_SEQ_RUNCNT_EN
        check("run_cnt", BW'(run_cnt), BW'(runs_mdl));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
